// File: rtl/sobel_window_gen.sv
// sobel_window_gen: 3x3 neighbourhood generator for the Sobel kernel.
// Takes one pixel column per transfer and emits bordered raster-order windows.
module sobel_window_gen #(
    parameter int DATA_W      = 8,
    parameter int IMG_ROWS    = 559,
    parameter int IMG_COLS    = 699,
    parameter int BORDER_MODE = 0
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_ni,
    input  logic [DATA_W-1:0]   in_top_i,
    input  logic [DATA_W-1:0]   in_mid_i,
    input  logic [DATA_W-1:0]   in_bot_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [9*DATA_W-1:0] out_win_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_sof_o,
    output logic                out_eol_o,
    output logic                out_eof_o
);

    localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int CW    = 3 * DATA_W;
    localparam int WW    = 9 * DATA_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
    localparam bit REPL = (BORDER_MODE != 0);

    typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CW-1:0]    p1_q, p1_d;
    logic [CW-1:0]    p2_q, p2_d;
    logic [WW-1:0]    win_q, win_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;

    logic              slot_free;
    logic              in_ready;
    logic              in_acc;
    logic [DATA_W-1:0] top_in;
    logic [DATA_W-1:0] bot_in;
    logic [CW-1:0]     col_in;
    logic [CW-1:0]     edge_col;

    // Column vectors hold top at index 0; window tap k = 3*row + col.
    function automatic logic [WW-1:0] pack_win(
        input logic [CW-1:0] l,
        input logic [CW-1:0] c,
        input logic [CW-1:0] r
    );
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            w[(3*i)*DATA_W   +: DATA_W] = l[i*DATA_W +: DATA_W];
            w[(3*i+1)*DATA_W +: DATA_W] = c[i*DATA_W +: DATA_W];
            w[(3*i+2)*DATA_W +: DATA_W] = r[i*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    always_comb begin
        slot_free = !valid_q || out_ready_i;
        in_ready  = slot_free && (state_q != ST_FLUSH);
        in_acc    = in_valid_i && in_ready;

        // Row borders are resolved on entry, so stored columns are final.
        top_in = in_top_i;
        if (row_q == '0) begin
            top_in = REPL ? in_mid_i : '0;
        end
        bot_in = in_bot_i;
        if (row_q == ROW_LAST) begin
            bot_in = REPL ? in_mid_i : '0;
        end
        col_in   = {bot_in, in_mid_i, top_in};
        edge_col = REPL ? p1_q : '0;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        valid_d = slot_free ? 1'b0 : valid_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;

        unique case (state_q)
            ST_FILL: begin
                if (in_acc) begin
                    p1_d    = col_in;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_acc) begin
                    win_d   = pack_win((col_q == '0) ? edge_col : p2_q,
                                       p1_q, col_in);
                    valid_d = 1'b1;
                    sof_d   = (row_q == '0) && (col_q == '0);
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    p2_d    = p1_q;
                    p1_d    = col_in;
                    col_d   = col_q + COL_W'(1);
                    if (col_d == COL_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    win_d   = pack_win(p2_q, p1_q, edge_col);
                    valid_d = 1'b1;
                    sof_d   = (row_q == '0) && (COL_LAST == '0);
                    eol_d   = 1'b1;
                    eof_d   = (row_q == ROW_LAST);
                    col_d   = '0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            state_q <= ST_FILL;
            col_q   <= '0;
            row_q   <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_win_o   = win_q;
    assign out_valid_o = valid_q;
    assign out_sof_o   = sof_q;
    assign out_eol_o   = eol_q;
    assign out_eof_o   = eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: scoreboard plus vector table for a 4x5 frame,
// zero-fill and replicate border instances driven in lock-step.
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int R = 4;
    localparam int C = 5;
    localparam int N = R * C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] top = '0;
    logic [W-1:0] mid = '0;
    logic [W-1:0] bot = '0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;

    logic in_ready0, in_ready1;
    logic [9*W-1:0] win0, win1;
    logic v0, v1, sof0, sof1, eol0, eol1, eof0, eof1;

    always #5 clk = ~clk;

    sobel_window_gen #(.DATA_W(W), .IMG_ROWS(R), .IMG_COLS(C),
                       .BORDER_MODE(0)) dut0 (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .in_top_i(top), .in_mid_i(mid), .in_bot_i(bot),
        .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .out_win_o(win0), .out_valid_o(v0), .out_ready_i(out_ready),
        .out_sof_o(sof0), .out_eol_o(eol0), .out_eof_o(eof0));

    sobel_window_gen #(.DATA_W(W), .IMG_ROWS(R), .IMG_COLS(C),
                       .BORDER_MODE(1)) dut1 (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .in_top_i(top), .in_mid_i(mid), .in_bot_i(bot),
        .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .out_win_o(win1), .out_valid_o(v1), .out_ready_i(out_ready),
        .out_sof_o(sof1), .out_eol_o(eol1), .out_eof_o(eof1));

    typedef struct {
        logic [71:0] win;
        logic [2:0]  fl;
    } exp_t;

    typedef struct {
        int          mode;
        int          idx;
        bit          chk_win;
        logic [71:0] win;
        logic [2:0]  fl;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    logic [71:0] cap0[N];
    logic [71:0] cap1[N];
    logic [2:0]  capf0[N];
    logic [2:0]  capf1[N];
    int ncap0 = 0;
    int ncap1 = 0;
    bit cap_en = 0;
    bit rand_rdy = 0;
    bit force_stall = 0;
    int stall_row = -1;

    vec_t tbl[10];

    function automatic logic [7:0] pix(int r, int c);
        return 8'(16 * r + c);
    endfunction

    function automatic logic [71:0] model(int r, int c, int m);
        logic [71:0] w;
        int rr, cc;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - 1;
                cc = c + j - 1;
                if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
                    if (rr < 0) rr = 0;
                    if (rr >= R) rr = R - 1;
                    if (cc < 0) cc = 0;
                    if (cc >= C) cc = C - 1;
                    w[(3*i+j)*8 +: 8] = (m == 0) ? 8'h00 : pix(rr, cc);
                end else begin
                    w[(3*i+j)*8 +: 8] = pix(rr, cc);
                end
            end
        end
        return w;
    endfunction

    function automatic logic [71:0] mkwin(
        logic [7:0] t0, logic [7:0] t1, logic [7:0] t2,
        logic [7:0] t3, logic [7:0] t4, logic [7:0] t5,
        logic [7:0] t6, logic [7:0] t7, logic [7:0] t8);
        return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
    endfunction

    function automatic vec_t mkvec(int m, int idx, bit cw,
                                   logic [71:0] w, logic [2:0] f);
        vec_t v;
        v.mode = m;
        v.idx = idx;
        v.chk_win = cw;
        v.win = w;
        v.fl = f;
        return v;
    endfunction

    task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(int r, int c);
        exp_t e;
        e.fl = {(r == 0 && c == 0), (c == C - 1), (r == R - 1 && c == C - 1)};
        e.win = model(r, c, 0);
        q0.push_back(e);
        e.win = model(r, c, 1);
        q1.push_back(e);
    endtask

    task automatic take(int m, logic [71:0] w, logic [2:0] f);
        exp_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_win%0d: got window %h, expected none", m, w);
            return;
        end
        if (m == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("win_m%0d", m), w, e.win);
        chk($sformatf("flags_m%0d", m), f, e.fl);
        if (cap_en) begin
            if (m == 0 && ncap0 < N) begin
                cap0[ncap0] = w;
                capf0[ncap0] = f;
                ncap0++;
            end
            if (m == 1 && ncap1 < N) begin
                cap1[ncap1] = w;
                capf1[ncap1] = f;
                ncap1++;
            end
        end
    endtask

    // Output-side monitor and scoreboard.
    initial begin
        logic [71:0] hold0, hold1;
        bit stall_prev;
        stall_prev = 0;
        hold0 = '0;
        hold1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    chk("stable_win0", win0, hold0);
                    chk("stable_win1", win1, hold1);
                    chk("stable_valid", v0, 1);
                end
                if (v0 && !out_ready) chk("in_ready_stall", in_ready0, 0);
                if (v0 && out_ready) take(0, win0, {sof0, eol0, eof0});
                if (v1 && out_ready) take(1, win1, {sof1, eol1, eof1});
                stall_prev = v0 && !out_ready;
                hold0 = win0;
                hold1 = win1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = force_stall ? 1'b0
                      : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic send_col(int r, int c);
        int n;
        bit acc;
        n = 0;
        top = (r == 0) ? 8'hFF : pix(r - 1, c);
        mid = pix(r, c);
        bot = (r == R - 1) ? 8'hFF : pix(r + 1, c);
        in_valid = 1'b1;
        forever begin
            acc = in_ready0;
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: col (%0d,%0d) not taken, expected accept", r, c);
                #1 in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (c >= 1) push(r, c - 1);
        if (c == C - 1) push(r, c);
        if (r == stall_row && c == C - 1) force_stall = 1;
        @(negedge clk);
        if (c >= 1) chk("latency_valid", v0, 1);
        if (c == C - 1) chk("flush_in_ready", in_ready0, 0);
        if (force_stall) begin
            repeat (3) @(negedge clk);
            force_stall = 0;
        end
    endtask

    task automatic send_frame(int gap_max);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                repeat ($urandom_range(0, gap_max)) @(negedge clk);
                send_col(r, c);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q0", 72'(q0.size()), 0);
        chk("drain_q1", 72'(q1.size()), 0);
    endtask

    initial begin
        logic [71:0] gw;
        logic [2:0] gf;
        bit ff_seen;

        tbl[0] = mkvec(0, 0, 1, mkwin(0, 0, 0, 0, 8'h00, 8'h01,
                                      0, 8'h10, 8'h11), 3'b100);
        tbl[1] = mkvec(0, 14, 1, mkwin(8'h13, 8'h14, 0, 8'h23, 8'h24, 0,
                                       8'h33, 8'h34, 0), 3'b010);
        tbl[2] = mkvec(1, 0, 1, mkwin(8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                                      8'h01, 8'h10, 8'h10, 8'h11), 3'b100);
        tbl[3] = mkvec(1, 19, 1, mkwin(8'h23, 8'h24, 8'h24, 8'h33, 8'h34,
                                       8'h34, 8'h33, 8'h34, 8'h34), 3'b011);
        tbl[4] = mkvec(0, 4, 0, '0, 3'b010);
        tbl[5] = mkvec(0, 9, 0, '0, 3'b010);
        tbl[6] = mkvec(0, 19, 0, '0, 3'b011);
        tbl[7] = mkvec(0, 1, 0, '0, 3'b000);
        tbl[8] = mkvec(0, 5, 0, '0, 3'b000);
        tbl[9] = mkvec(1, 15, 0, '0, 3'b000);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid0", v0, 0);
        chk("rst_win0", win0, 0);
        chk("rst_flags0", {sof0, eol0, eof0}, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_win1", win1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready0, 1);

        cap_en = 1;
        send_frame(0);
        wait_drain();
        cap_en = 0;

        chk("cap_count0", 72'(ncap0), N);
        chk("cap_count1", 72'(ncap1), N);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].mode == 0) begin
                gw = cap0[tbl[i].idx];
                gf = capf0[tbl[i].idx];
            end else begin
                gw = cap1[tbl[i].idx];
                gf = capf1[tbl[i].idx];
            end
            if (tbl[i].chk_win) chk($sformatf("tbl%0d_win", i), gw, tbl[i].win);
            chk($sformatf("tbl%0d_flags", i), gf, tbl[i].fl);
        end
        ff_seen = 0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 9; k++) begin
                if (cap0[i][k*8 +: 8] == 8'hFF) ff_seen = 1;
            end
        end
        chk("no_ff_zero_mode", ff_seen, 0);

        rand_rdy = 1;
        stall_row = 1;
        send_frame(3);
        wait_drain();
        stall_row = -1;
        rand_rdy = 0;
        repeat (2) @(negedge clk);

        for (int c = 0; c < C; c++) send_col(0, c);
        for (int c = 0; c < 4; c++) send_col(1, c);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_valid", v0, 0);
        chk("midrst_win0", win0, 0);
        chk("midrst_win1", win1, 0);
        chk("midrst_q0", 72'(q0.size()), 0);
        send_col(0, 0);
        chk("midrst_first_col", v0, 0);
        send_col(0, 1);
        chk("midrst_sof", sof0, 1);
        for (int c = 2; c < C; c++) send_col(0, c);
        for (int r = 1; r < R; r++) begin
            for (int c = 0; c < C; c++) send_col(r, c);
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Parametrised 3x3 neighbourhood generator feeding the Sobel kernel. It accepts one image column per transfer: three vertically adjacent pixels from the line buffers. It emits one fully bordered 3x3 window per centre pixel, in raster order. It replaces the fixed-size, zero-border, handshake-less window stage with configurable width, frame size and border mode, valid/ready flow control on both sides, an end-of-row flush and frame markers.

Parameters:
DATA_W, 8, pixel width in bits
IMG_ROWS, 559, frame height in pixels (must be >= 2)
IMG_COLS, 699, frame width in pixels (must be >= 2)
BORDER_MODE, 0, out-of-frame tap policy: 0 = zero fill, 1 = replicate the nearest in-frame pixel

Ports:
sys_clk_i  in  1  clock; all logic on the rising edge
sys_rst_ni  in  1  synchronous, active-low reset
in_top_i  in  DATA_W  pixel from row r-1 of the incoming column
in_mid_i  in  DATA_W  pixel from row r of the incoming column
in_bot_i  in  DATA_W  pixel from row r+1 of the incoming column
in_valid_i  in  1  the incoming column is valid
in_ready_o  out  1  the block accepts the column this cycle
out_win_o  out  9*DATA_W  window; tap k = 3*i+j in bits [k*DATA_W +: DATA_W]; i: 0=top, 1=mid, 2=bot; j: 0=left, 1=centre, 2=right
out_valid_o  out  1  the window is valid
out_ready_i  in  1  downstream accepts the window
out_sof_o  out  1  the window centre is (0,0)
out_eol_o  out  1  the window centre is in column IMG_COLS-1
out_eof_o  out  1  the window centre is (IMG_ROWS-1, IMG_COLS-1)

Behaviour:
- Reset (sys_rst_ni=0 at a clock edge): FSM=FILL; row/column counters=0; column registers=0; out_win_o=0; out_valid_o=0; all flags=0. Reset takes effect mid-frame or mid-stall with no partial output; the next accepted column is treated as column 0 of row 0.
- Transfers: in accept = in_valid_i & in_ready_o; out accept = out_valid_o & out_ready_i.
- The output is a single registered stage. It may load when out_valid_o=0 or out_ready_i=1 ("slot free").
- in_ready_o = slot free & (state != FLUSH). It is combinational from out_ready_i, with no path from in_valid_i.
- Two column registers hold the two previously accepted columns, P1 (newest) and P2.
- FSM states:
  - FILL: waiting for column 0 of a row. On accept: P1 <= input; no window; go to RUN.
  - RUN: on accept of column c+1, load the window for centre c: left=P1 (border at c=0), centre=P1, right=input. Then shift P2 <= P1, P1 <= input. If c+1 == IMG_COLS-1, go to FLUSH.
  - FLUSH: takes no input. When the slot is free, load the window for centre IMG_COLS-1 with right column = border, then go to FILL. Row counter advances, wrapping IMG_ROWS-1 -> 0.
  - Correction for RUN: for centre c >= 1, left=P2, centre=P1.
- Latency: the window for centre c < IMG_COLS-1 is valid the cycle after column c+1 is accepted. The last-column window is valid the cycle after the slot frees in FLUSH. There is one bubble per row on the input side.
- Border rows: at centre row 0, in_top_i is ignored. At row IMG_ROWS-1, in_bot_i is ignored; upstream may drive any value.
- BORDER_MODE=0: every out-of-frame tap is 0.
- BORDER_MODE=1: an out-of-frame row takes the mid-row value of the same column. An out-of-frame column takes the centre-column value of the same row. A corner applies both rules, giving the centre pixel.
- Counters: column and row counters are $clog2-sized and track the centre of the next window to be produced. Flags are registered with out_win_o. All outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous events: an out accept and a new load in the same cycle give back-to-back windows with no bubble. in_valid_i while in FLUSH is held off (in_ready_o=0) and its data is not consumed.

Test Plan:
- ROWS=4, COLS=5, MODE=0; pixel(r,c)=16r+c; top at row 0 and bot at row 3 driven to 0xFF; out_ready_i=1 -> 20 windows in raster order. Centre (0,0) window = {0,0,0, 0,0x00,0x01, 0,0x10,0x11}. Centre (2,4) window = {0x13,0x14,0, 0x23,0x24,0, 0x33,0x34,0}. No 0xFF appears anywhere.
- Same frame with MODE=1 -> centre (0,0) window = {00,00,01, 00,00,01, 10,10,11}. Centre (3,4) window = {23,24,24, 33,34,34, 33,34,34}.
- Flags -> out_sof_o only on window 0; out_eol_o on windows 4,9,14,19; out_eof_o only on window 19. The next frame restarts at (0,0) with out_sof_o=1.
- Random out_ready_i (50%), including a stall held during FLUSH -> window sequence identical to the unstalled run. out_win_o is stable while stalled. in_ready_o=0 throughout FLUSH and whenever out_valid_o & !out_ready_i.
- sys_rst_ni=0 for one cycle at centre (1,2) with out_valid_o=1 -> next cycle out_valid_o=0 and out_win_o=0. The next column fed produces no window; the second fed column produces a window with out_sof_o=1.
- in_valid_i gaps of 1-3 cycles between columns -> no spurious out_valid_o; latency from column c+1 accept to window c is exactly 1 cycle.
